map_table_ss: RTL and testbench

Superscalar register map table with branch checkpointing; next generation of the single-issue map table. Maps each architectural register to the ROB tag of its youngest in-flight producer and a ready (t_plus) bit. Serves DISPATCH_WIDTH rename lanes per cycle, absorbs CDB_WIDTH broadcasts and RETIRE_WIDTH retirements, and holds NUM_CKPT in-order snapshots for single-cycle branch-mispredict recovery. Sits between decode/dispatch and the RS/ROB.

---
 rtl/map_table_ss_if.sv | 37 +++
 rtl/map_table_ss.sv | 143 ++++++++++++++
 tb/tb_map_table_ss.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/map_table_ss_if.sv
// map_table_ss_if: rename lookup, dispatch write, CDB, retire and checkpoint
// control bus of the superscalar map table.
interface map_table_ss_if #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int CDB_WIDTH      = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int ROB_TAG_W      = 5,
  parameter int NUM_CKPT       = 4
);
  localparam int CKPT_W = $clog2(NUM_CKPT);
  logic [DISPATCH_WIDTH-1:0]           disp_valid, disp_rd_valid, disp_rs1_valid, disp_rs2_valid;
  logic [DISPATCH_WIDTH*5-1:0]         disp_rd, disp_rs1, disp_rs2;
  logic [DISPATCH_WIDTH*ROB_TAG_W-1:0] disp_rob_tag, src1_tag, src2_tag;
  logic [DISPATCH_WIDTH-1:0]           src1_busy, src2_busy, src1_ready, src2_ready;
  logic [CDB_WIDTH-1:0]                cdb_valid;
  logic [CDB_WIDTH*ROB_TAG_W-1:0]      cdb_tag;
  logic [RETIRE_WIDTH-1:0]             ret_valid;
  logic [RETIRE_WIDTH*ROB_TAG_W-1:0]   ret_tag;
  logic                                ckpt_take, ckpt_release, ckpt_restore;
  logic [CKPT_W-1:0]                   ckpt_restore_id, ckpt_alloc_id;
  logic                                ckpt_full, ckpt_err;
  logic [CKPT_W:0]                     ckpt_count;
  modport master (
    output disp_valid, disp_rd_valid, disp_rs1_valid, disp_rs2_valid, disp_rd, disp_rs1, disp_rs2,
           disp_rob_tag, cdb_valid, cdb_tag, ret_valid, ret_tag, ckpt_take, ckpt_release,
           ckpt_restore, ckpt_restore_id,
    input  src1_busy, src2_busy, src1_ready, src2_ready, src1_tag, src2_tag, ckpt_alloc_id,
           ckpt_full, ckpt_err, ckpt_count
  );
  modport slave (
    input  disp_valid, disp_rd_valid, disp_rs1_valid, disp_rs2_valid, disp_rd, disp_rs1, disp_rs2,
           disp_rob_tag, cdb_valid, cdb_tag, ret_valid, ret_tag, ckpt_take, ckpt_release,
           ckpt_restore, ckpt_restore_id,
    output src1_busy, src2_busy, src1_ready, src2_ready, src1_tag, src2_tag, ckpt_alloc_id,
           ckpt_full, ckpt_err, ckpt_count
  );
endinterface

// File: rtl/map_table_ss.sv
// map_table_ss: superscalar register map table with in-order branch checkpoints
// and single-cycle mispredict recovery.
module map_table_ss #(
  parameter int NUM_ARCH_REGS  = 32,
  parameter int ROB_TAG_W      = 5,
  parameter int DISPATCH_WIDTH = 2,
  parameter int CDB_WIDTH      = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int NUM_CKPT       = 4
) (
  input logic          clock,
  input logic          reset_n,
  map_table_ss_if.slave bus
);
  localparam int CKPT_W = $clog2(NUM_CKPT);
  localparam int TW     = ROB_TAG_W;
  localparam logic [CKPT_W:0] FULL = (CKPT_W+1)'(NUM_CKPT);
  typedef struct packed {
    logic          busy;
    logic [TW-1:0] tag;
    logic          tp;
  } ent_t;
  ent_t tbl_q [NUM_ARCH_REGS];
  ent_t tbl_d [NUM_ARCH_REGS];
  ent_t snap_q [NUM_CKPT][NUM_ARCH_REGS];
  ent_t snap_d [NUM_CKPT][NUM_ARCH_REGS];
  ent_t l1 [DISPATCH_WIDTH];
  ent_t l2 [DISPATCH_WIDTH];
  logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d, rpos;
  logic [CKPT_W:0]   cnt_q, cnt_d, base_cnt;
  logic              err_q, err_d, restore_ok, take_ok, rel_ok;
  logic [CDB_WIDTH-1:0]                cv;
  logic [CDB_WIDTH*TW-1:0]             ct;
  logic [RETIRE_WIDTH-1:0]             rv;
  logic [RETIRE_WIDTH*TW-1:0]          rt;
  logic [DISPATCH_WIDTH-1:0]           dv, drv;
  logic [DISPATCH_WIDTH*5-1:0]         drd;
  logic [DISPATCH_WIDTH*TW-1:0]        dtag;
  assign cv   = bus.cdb_valid;
  assign ct   = bus.cdb_tag;
  assign rv   = bus.ret_valid;
  assign rt   = bus.ret_tag;
  assign dv   = bus.disp_valid;
  assign drv  = bus.disp_rd_valid;
  assign drd  = bus.disp_rd;
  assign dtag = bus.disp_rob_tag;

  function automatic logic cdb_hit(input logic [TW-1:0] t);
    logic h;
    h = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++) h = h | (cv[c] && ct[c*TW +: TW] == t);
    return h;
  endfunction

  function automatic logic ret_hit(input logic [TW-1:0] t);
    logic h;
    h = 1'b0;
    for (int r = 0; r < RETIRE_WIDTH; r++) h = h | (rv[r] && rt[r*TW +: TW] == t);
    return h;
  endfunction

  // Applies this cycle's CDB wakeups and retire frees; shared by table and snapshots.
  function automatic ent_t evolve(input ent_t e);
    ent_t o;
    o = e;
    if (e.busy && cdb_hit(e.tag)) o.tp = 1'b1;
    if (e.busy && ret_hit(e.tag)) o = '0;
    return o;
  endfunction

  function automatic ent_t look(input int j, input logic [4:0] s, input logic sv);
    ent_t o;
    o = tbl_q[s];
    o.tp = o.tp | (o.busy & cdb_hit(o.tag));
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (i < j && dv[i] && drv[i] && drd[i*5 +: 5] == s) o = {1'b1, dtag[i*TW +: TW], 1'b0};
    return (sv && s != 5'd0) ? o : '0;
  endfunction

  always_comb begin
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      l1[j] = look(j, bus.disp_rs1[j*5 +: 5], bus.disp_rs1_valid[j]);
      l2[j] = look(j, bus.disp_rs2[j*5 +: 5], bus.disp_rs2_valid[j]);
    end
  end

  for (genvar g = 0; g < DISPATCH_WIDTH; g++) begin : g_out
    assign bus.src1_busy[g]            = l1[g].busy;
    assign bus.src1_tag[g*TW +: TW]    = l1[g].tag;
    assign bus.src1_ready[g]           = l1[g].tp;
    assign bus.src2_busy[g]            = l2[g].busy;
    assign bus.src2_tag[g*TW +: TW]    = l2[g].tag;
    assign bus.src2_ready[g]           = l2[g].tp;
  end

  // A restore target is valid when its age offset from head is below the occupancy.
  always_comb begin
    rpos       = bus.ckpt_restore_id - head_q;
    restore_ok = bus.ckpt_restore && ({1'b0, rpos} < cnt_q);
    base_cnt   = restore_ok ? {1'b0, rpos} : cnt_q;
    take_ok    = bus.ckpt_take && !restore_ok && cnt_q != FULL;
    rel_ok     = bus.ckpt_release && base_cnt != '0;
    cnt_d      = base_cnt + (CKPT_W+1)'(take_ok) - (CKPT_W+1)'(rel_ok);
    head_d     = head_q + CKPT_W'(rel_ok);
    tail_d     = restore_ok ? bus.ckpt_restore_id : tail_q + CKPT_W'(take_ok);
    err_d      = err_q | (bus.ckpt_take & !restore_ok & cnt_q == FULL)
               | (bus.ckpt_release & !rel_ok) | (bus.ckpt_restore & !restore_ok);
  end

  always_comb begin
    for (int r = 0; r < NUM_ARCH_REGS; r++)
      tbl_d[r] = evolve(restore_ok ? snap_q[bus.ckpt_restore_id][r] : tbl_q[r]);
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (!restore_ok && dv[i] && drv[i] && drd[i*5 +: 5] != 5'd0)
        tbl_d[drd[i*5 +: 5]] = {1'b1, dtag[i*TW +: TW], 1'b0};
    for (int s = 0; s < NUM_CKPT; s++)
      for (int r = 0; r < NUM_ARCH_REGS; r++) snap_d[s][r] = evolve(snap_q[s][r]);
    if (take_ok) snap_d[tail_q] = tbl_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tbl_q  <= '{default: '0};
      snap_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      tbl_q  <= tbl_d;
      snap_q <= snap_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.ckpt_alloc_id = tail_q;
  assign bus.ckpt_full     = cnt_q == FULL;
  assign bus.ckpt_count    = cnt_q;
  assign bus.ckpt_err      = err_q;
endmodule

// File: tb/tb_map_table_ss.sv
// tb_map_table_ss: directed scenarios plus randomized traffic checked every cycle
// against a queue-of-tables reference model.
module tb_map_table_ss;
  localparam int D = 2, C = 2, R = 2, TW = 5, N = 4, NR = 32;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  map_table_ss_if #(.DISPATCH_WIDTH(D), .CDB_WIDTH(C), .RETIRE_WIDTH(R), .ROB_TAG_W(TW), .NUM_CKPT(N)) bus ();
  map_table_ss #(.NUM_ARCH_REGS(NR), .ROB_TAG_W(TW), .DISPATCH_WIDTH(D), .CDB_WIDTH(C),
                 .RETIRE_WIDTH(R), .NUM_CKPT(N)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct { bit b; int t; bit p; } me_t;
  typedef struct { me_t e[NR]; } tbl_t;
  tbl_t mt;
  tbl_t cq[$];
  int   mhead;
  bit   merr;
  int   n_cmp = 0, n_bad = 0;

  function automatic int fld(input logic [63:0] v, input int i, input int w);
    return int'((v >> (i*w)) & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic bit any_tag(input logic [63:0] v, input logic [63:0] tg, input int n, input int t);
    for (int k = 0; k < n; k++) if (v[k] && fld(tg, k, TW) == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic me_t evo(input me_t x);
    me_t o;
    o = x;
    if (x.b && any_tag(64'(bus.cdb_valid), 64'(bus.cdb_tag), C, x.t)) o.p = 1'b1;
    if (x.b && any_tag(64'(bus.ret_valid), 64'(bus.ret_tag), R, x.t)) o = '{1'b0, 0, 1'b0};
    return o;
  endfunction

  function automatic me_t mlook(input int j, input int s, input bit sv);
    me_t x;
    if (!sv || s == 0) return '{1'b0, 0, 1'b0};
    for (int i = j - 1; i >= 0; i--)
      if (bus.disp_valid[i] && bus.disp_rd_valid[i] && fld(64'(bus.disp_rd), i, 5) == s)
        return '{1'b1, fld(64'(bus.disp_rob_tag), i, TW), 1'b0};
    x = mt.e[s];
    if (x.b && any_tag(64'(bus.cdb_valid), 64'(bus.cdb_tag), C, x.t)) x.p = 1'b1;
    return x;
  endfunction

  function automatic logic [31:0] pk(input bit b, input int t, input bit p);
    return 32'({b, TW'(t), p});
  endfunction

  function automatic logic [31:0] dsrc(input int j, input int k);
    return k == 0 ? 32'({bus.src1_busy[j], bus.src1_tag[j*TW +: TW], bus.src1_ready[j]})
                  : 32'({bus.src2_busy[j], bus.src2_tag[j*TW +: TW], bus.src2_ready[j]});
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mt.e[r] = '{1'b0, 0, 1'b0};
    cq.delete();
    mhead = 0;
    merr  = 1'b0;
  endtask

  task automatic model_step();
    tbl_t nt, tmp;
    int   size, pos;
    bit   rok, full;
    size = cq.size();
    full = size == N;
    pos  = ((int'(bus.ckpt_restore_id) - mhead) % N + N) % N;
    rok  = bus.ckpt_restore && pos < size;
    nt   = rok ? cq[pos] : mt;
    for (int r = 0; r < NR; r++) nt.e[r] = evo(nt.e[r]);
    if (!rok)
      for (int i = 0; i < D; i++)
        if (bus.disp_valid[i] && bus.disp_rd_valid[i] && fld(64'(bus.disp_rd), i, 5) != 0)
          nt.e[fld(64'(bus.disp_rd), i, 5)] = '{1'b1, fld(64'(bus.disp_rob_tag), i, TW), 1'b0};
    for (int q = 0; q < cq.size(); q++) begin
      tmp = cq[q];
      for (int r = 0; r < NR; r++) tmp.e[r] = evo(tmp.e[r]);
      cq[q] = tmp;
    end
    if (rok) while (cq.size() > pos) void'(cq.pop_back());
    if (bus.ckpt_restore && !rok) merr = 1'b1;
    if (bus.ckpt_release) begin
      if (cq.size() == 0) merr = 1'b1;
      else begin
        void'(cq.pop_front());
        mhead = (mhead + 1) % N;
      end
    end
    if (bus.ckpt_take && !rok) begin
      if (full) merr = 1'b1;
      else cq.push_back(nt);
    end
    mt = nt;
  endtask

  task automatic check_all();
    me_t x;
    for (int j = 0; j < D; j++) begin
      x = mlook(j, fld(64'(bus.disp_rs1), j, 5), bus.disp_rs1_valid[j]);
      cmp($sformatf("lane%0d_src1", j), dsrc(j, 0), pk(x.b, x.t, x.p));
      x = mlook(j, fld(64'(bus.disp_rs2), j, 5), bus.disp_rs2_valid[j]);
      cmp($sformatf("lane%0d_src2", j), dsrc(j, 1), pk(x.b, x.t, x.p));
    end
    cmp("alloc_id", 32'(bus.ckpt_alloc_id), 32'((mhead + cq.size()) % N));
    cmp("full", 32'(bus.ckpt_full), 32'(cq.size() == N));
    cmp("count", 32'(bus.ckpt_count), 32'(cq.size()));
    cmp("err", 32'(bus.ckpt_err), 32'(merr));
  endtask

  task automatic zero_in();
    bus.disp_valid = '0; bus.disp_rd_valid = '0; bus.disp_rs1_valid = '0; bus.disp_rs2_valid = '0;
    bus.disp_rd = '0; bus.disp_rs1 = '0; bus.disp_rs2 = '0; bus.disp_rob_tag = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.ret_valid = '0; bus.ret_tag = '0;
    bus.ckpt_take = 1'b0; bus.ckpt_release = 1'b0; bus.ckpt_restore = 1'b0; bus.ckpt_restore_id = '0;
  endtask

  task automatic lane(input int i, input bit v, input int rd, input bit rdv, input int tag,
                      input int rs1, input bit r1v, input int rs2, input bit r2v);
    bus.disp_valid[i] = v;   bus.disp_rd[i*5 +: 5] = 5'(rd); bus.disp_rd_valid[i] = rdv;
    bus.disp_rob_tag[i*TW +: TW] = TW'(tag);
    bus.disp_rs1[i*5 +: 5] = 5'(rs1); bus.disp_rs1_valid[i] = r1v;
    bus.disp_rs2[i*5 +: 5] = 5'(rs2); bus.disp_rs2_valid[i] = r2v;
  endtask

  task automatic rand_in();
    for (int i = 0; i < D; i++)
      lane(i, $urandom_range(3) != 0, int'($urandom_range(7)), $urandom_range(3) != 0, int'($urandom_range(11)),
           int'($urandom_range(7)), $urandom_range(1) == 1, int'($urandom_range(7)), $urandom_range(1) == 1);
    for (int c = 0; c < C; c++) begin
      bus.cdb_valid[c] = $urandom_range(1) == 1;
      bus.cdb_tag[c*TW +: TW] = TW'($urandom_range(11));
    end
    for (int r = 0; r < R; r++) begin
      bus.ret_valid[r] = $urandom_range(3) == 0;
      bus.ret_tag[r*TW +: TW] = TW'($urandom_range(11));
    end
    bus.ckpt_take       = $urandom_range(4) == 0;
    bus.ckpt_release    = $urandom_range(6) == 0;
    bus.ckpt_restore    = $urandom_range(11) == 0;
    bus.ckpt_restore_id = 2'($urandom_range(3));
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    @(negedge clock);
  endtask

  initial begin
    model_reset();
    zero_in();
    settle();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    settle();
    cmp("rst_count", 32'(bus.ckpt_count), 0);
    cmp("rst_alloc", 32'(bus.ckpt_alloc_id), 0);
    cmp("rst_full", 32'(bus.ckpt_full), 0);
    cmp("rst_err", 32'(bus.ckpt_err), 0);
    tick();
    // intra-bundle forwarding, youngest lane owns x5 afterwards
    lane(0, 1, 5, 1, 3, 0, 0, 0, 0); lane(1, 1, 5, 1, 4, 5, 1, 0, 0);
    settle(); cmp("fwd_x5", dsrc(1, 0), pk(1, 3, 0)); tick();
    zero_in(); lane(0, 0, 0, 0, 0, 5, 1, 0, 0);
    settle(); cmp("x5_tag4", dsrc(0, 0), pk(1, 4, 0)); tick();
    // CDB bypass, retire clear, x0 write ignored
    zero_in(); lane(0, 1, 7, 1, 6, 0, 0, 0, 0); settle(); tick();
    zero_in(); bus.cdb_valid[0] = 1'b1; bus.cdb_tag[TW-1:0] = 5'd6; lane(0, 0, 0, 0, 0, 7, 1, 0, 0);
    settle(); cmp("cdb_bypass_x7", dsrc(0, 0), pk(1, 6, 1)); tick();
    zero_in(); bus.ret_valid[0] = 1'b1; bus.ret_tag[TW-1:0] = 5'd6; lane(1, 1, 0, 1, 9, 0, 0, 0, 0);
    settle(); tick();
    zero_in(); lane(0, 0, 0, 0, 0, 7, 1, 0, 0); lane(1, 0, 0, 0, 0, 0, 0, 0, 1);
    settle(); cmp("retired_x7", dsrc(0, 0), 0); cmp("x0_zero", dsrc(1, 1), 0); tick();
    // dispatch beats retire of the previous producer
    zero_in(); lane(0, 1, 9, 1, 1, 0, 0, 0, 0); settle(); tick();
    zero_in(); lane(0, 1, 9, 1, 2, 0, 0, 0, 0); bus.ret_valid[0] = 1'b1; bus.ret_tag[TW-1:0] = 5'd1;
    settle(); tick();
    zero_in(); lane(0, 0, 0, 0, 0, 9, 1, 0, 0);
    settle(); cmp("x9_disp_wins", dsrc(0, 0), pk(1, 2, 0)); tick();
    // snapshot tracks CDB, restore returns it
    zero_in(); lane(0, 1, 3, 1, 1, 0, 0, 0, 0); settle(); tick();
    zero_in(); bus.ckpt_take = 1'b1; settle(); cmp("take_alloc0", 32'(bus.ckpt_alloc_id), 0); tick();
    zero_in(); lane(0, 1, 3, 1, 5, 0, 0, 0, 0); settle(); cmp("count1", 32'(bus.ckpt_count), 1); tick();
    zero_in(); bus.cdb_valid[0] = 1'b1; bus.cdb_tag[TW-1:0] = 5'd1; settle(); tick();
    zero_in(); bus.ckpt_restore = 1'b1; bus.ckpt_restore_id = 2'd0; settle(); tick();
    zero_in(); lane(0, 0, 0, 0, 0, 3, 1, 0, 0);
    settle(); cmp("restored_x3", dsrc(0, 0), pk(1, 1, 1));
    cmp("restore_count0", 32'(bus.ckpt_count), 0); cmp("restore_alloc0", 32'(bus.ckpt_alloc_id), 0); tick();
    // fill, overflow, partial restore, drain
    for (int k = 0; k < N; k++) begin zero_in(); bus.ckpt_take = 1'b1; settle(); tick(); end
    zero_in(); settle();
    cmp("full_flag", 32'(bus.ckpt_full), 1); cmp("full_count", 32'(bus.ckpt_count), 4);
    bus.ckpt_take = 1'b1; settle(); tick();
    zero_in(); settle();
    cmp("overflow_err", 32'(bus.ckpt_err), 1); cmp("overflow_count", 32'(bus.ckpt_count), 4);
    bus.ckpt_restore = 1'b1; bus.ckpt_restore_id = 2'd2; tick();
    zero_in(); settle();
    cmp("restore2_count", 32'(bus.ckpt_count), 2); cmp("restore2_alloc", 32'(bus.ckpt_alloc_id), 2);
    bus.ckpt_release = 1'b1; tick();
    zero_in(); bus.ckpt_release = 1'b1; settle(); tick();
    zero_in(); lane(0, 0, 0, 0, 0, 5, 1, 0, 0); settle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    cmp("async_rst_src", dsrc(0, 0), 0); cmp("async_rst_err", 32'(bus.ckpt_err), 0);
    cmp("async_rst_count", 32'(bus.ckpt_count), 0);
    check_all();
    tick();
    reset_n = 1'b1;
    zero_in(); bus.ckpt_release = 1'b1; settle(); tick();
    zero_in(); settle();
    cmp("underflow_err", 32'(bus.ckpt_err), 1); cmp("underflow_count", 32'(bus.ckpt_count), 0); tick();
    // randomized traffic with periodic resets to clear the sticky error
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 299) begin
        zero_in(); reset_n = 1'b0; model_reset(); settle(); tick(); reset_n = 1'b1;
      end else begin
        rand_in(); settle(); tick();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
